// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RISC-V M-extension unit.
// funct3 encodings follow the RV M-extension opcode map.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Multi-cycle RISC-V multiply/divide unit: one bit per cycle over a shared
// 2*XLEN accumulator, sign handled on magnitudes and reapplied in FIX.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [TAGW-1:0] tag_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [TAGW-1:0] tag_o
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned IW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_WORD = CW'(31);

    // Replace bits above 31 with bit 31 (sgn=1) or zero (sgn=0).
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int unsigned i = 32; i < XLEN; i++) begin
            r[i] = sgn & v[31];
        end
        return r;
    endfunction

    md_state_t         state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              is_w;
    logic              neg;
    logic [XLEN-1:0]   a_reg;
    logic [XLEN-1:0]   b_reg;
    logic [2*XLEN-1:0] acc;

    // Request decode and operand conditioning, evaluated in IDLE.
    logic              is_w_in;
    logic [2:0]        op_in;
    logic              ext_sgn;
    logic              a_sgn;
    logic              b_sgn;
    logic [XLEN-1:0]   a_ext;
    logic [XLEN-1:0]   b_ext;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              neg_in;
    logic [XLEN-1:0]   min_neg;
    logic              div0;
    logic              ovf;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        is_w_in = (XLEN == 64) && word_i;
        op_in   = funct3_i;
        if (is_w_in && (funct3_i inside {MD_MULH, MD_MULHSU, MD_MULHU})) begin
            op_in = MD_MUL;
        end
        ext_sgn = !(op_in inside {MD_DIVU, MD_REMU});
        a_sgn   = op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        b_sgn   = op_in inside {MD_MULH, MD_DIV, MD_REM};
        a_ext   = is_w_in ? ext32(op1_i, ext_sgn) : op1_i;
        b_ext   = is_w_in ? ext32(op2_i, ext_sgn) : op2_i;
        a_neg   = a_sgn & a_ext[XLEN-1];
        b_neg   = b_sgn & b_ext[XLEN-1];
        a_mag   = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_mag   = b_neg ? (~b_ext + 1'b1) : b_ext;
        neg_in  = (op_in inside {MD_REM, MD_REMU}) ? a_neg : (a_neg ^ b_neg);

        min_neg = '0;
        min_neg[XLEN-1] = 1'b1;
        if (is_w_in) begin
            min_neg = ext32(XLEN'(32'h8000_0000), 1'b1);
        end

        div0 = op_in[2] && (b_ext == '0);
        ovf  = (op_in inside {MD_DIV, MD_REM}) && (a_ext == min_neg) && (b_ext == '1);

        // op_in[1] separates REM/REMU from DIV/DIVU.
        if (div0) begin
            fast_res = op_in[1] ? a_ext : '1;
        end else begin
            fast_res = op_in[1] ? '0 : a_ext;
        end
        if (is_w_in) begin
            fast_res = ext32(fast_res, 1'b1);
        end
    end

    // One iteration: MSB-first shift-add for multiply, restoring step for divide.
    logic [IW-1:0]     idx;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN:0]     trial;
    logic              ge;
    logic [XLEN-1:0]   diff;
    logic [XLEN-1:0]   new_rem;

    always_comb begin
        idx     = cnt[IW-1:0];
        trial   = {acc[2*XLEN-1:XLEN], a_reg[idx]};
        ge      = trial >= {1'b0, b_reg};
        diff    = trial[XLEN-1:0] - b_reg;
        new_rem = ge ? diff : trial[XLEN-1:0];
        if (op[2]) begin
            acc_nxt = {new_rem, acc[XLEN-2:0], ge};
        end else begin
            acc_nxt = {acc[2*XLEN-2:0], 1'b0} + (b_reg[idx] ? {{XLEN{1'b0}}, a_reg} : '0);
        end
    end

    // Result selection with sign correction and W sign-extension.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg ? (~acc + 1'b1) : acc;
        quo_fix  = neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_fix  = neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        case (op)
            MD_MUL:                        fix_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               fix_res = quo_fix;
            default:                       fix_res = rem_fix;
        endcase
        if (is_w) begin
            fix_res = ext32(fix_res, 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= MD_MUL;
            is_w     <= 1'b0;
            neg      <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (flush_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        tag_o   <= tag_i;
                        op      <= op_in;
                        is_w    <= is_w_in;
                        neg     <= neg_in;
                        a_reg   <= a_mag;
                        b_reg   <= b_mag;
                        acc     <= '0;
                        ready_o <= 1'b0;
                        if (div0 || ovf) begin
                            result_o <= fast_res;
                            valid_o  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt   <= is_w_in ? CNT_WORD : CNT_FULL;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    result_o <= fix_res;
                    valid_o  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
